// File: rtl/memcpy_pkg.sv
// Shared constants, FSM state type and chunk-sizing helpers for the byte-lane copy engine.
package memcpy_pkg;
    localparam int LANES  = 8;
    localparam int ADDR_W = 64;
    localparam int SIZE_W = 15;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_t;

    // Bytes moved by the next chunk: min(LANES, remaining).
    function automatic logic [3:0] chunk_len(input logic [SIZE_W-1:0] rem);
        if (rem >= SIZE_W'(LANES)) begin
            return 4'(LANES);
        end
        return rem[3:0];
    endfunction

    function automatic logic [LANES-1:0] lane_mask(input logic [3:0] n);
        logic [LANES-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction
endpackage

// File: rtl/memcpy_lane_buf.sv
// One byte lane: holds the read byte until the write burst and flags that it has arrived.
module memcpy_lane_buf (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       capture,
    input  logic       valid,
    input  logic [7:0] data_in,
    output logic [7:0] data,
    output logic       got
);
    logic [7:0] data_reg;
    logic       got_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg <= '0;
            got_reg  <= 1'b0;
        end else if (clr) begin
            got_reg <= 1'b0;
        end else if (capture && valid && !got_reg) begin
            data_reg <= data_in;
            got_reg  <= 1'b1;
        end
    end

    assign data = data_reg;
    assign got  = got_reg;
endmodule

// File: rtl/memcpy_engine.sv
// Byte-granular copy engine: reads up to LANES bytes in parallel, then writes them, chunk by chunk.
module memcpy_engine
    import memcpy_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [ADDR_W-1:0]             src,
    input  logic [ADDR_W-1:0]             dst,
    input  logic [SIZE_W-1:0]             size,
    output logic                          done,
    output logic [LANES-1:0]              dram_en,
    output logic                          dram_rdwr,
    output logic [LANES-1:0][ADDR_W-1:0]  dram_addr,
    output logic [LANES-1:0][7:0]         dram_data_out,
    input  logic [LANES-1:0][7:0]         dram_data_in,
    input  logic [LANES-1:0]              dram_valid
);
    state_t                state_reg;
    logic [ADDR_W-1:0]     src_reg;
    logic [ADDR_W-1:0]     dst_reg;
    logic [SIZE_W-1:0]     size_reg;
    logic [SIZE_W-1:0]     offset_reg;
    logic [3:0]            n_reg;
    logic [LANES-1:0]      mask_reg;
    logic [LANES-1:0]      ack_reg;

    logic [LANES-1:0]      got;
    logic [LANES-1:0][7:0] buf_data;
    logic [LANES-1:0][7:0] fwd_data;
    logic                  buf_clr;
    logic                  buf_capture;
    logic                  rd_all;
    logic                  wr_all;
    logic [3:0]            start_n;
    logic [LANES-1:0]      start_mask;
    logic [SIZE_W-1:0]     next_offset;
    logic [3:0]            next_n;
    logic [LANES-1:0]      next_mask;

    assign buf_clr     = (state_reg == RD_REQ);
    assign buf_capture = (state_reg == RD_WAIT);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            memcpy_lane_buf u_buf (
                .clk     (clk),
                .reset   (reset),
                .clr     (buf_clr),
                .capture (buf_capture && mask_reg[gi]),
                .valid   (dram_valid[gi]),
                .data_in (dram_data_in[gi]),
                .data    (buf_data[gi]),
                .got     (got[gi])
            );
            // The last lane's byte arrives on the same edge the write burst is launched.
            assign fwd_data[gi] = (dram_valid[gi] && !got[gi]) ? dram_data_in[gi] : buf_data[gi];
        end
    endgenerate

    assign rd_all      = ((got | dram_valid) & mask_reg) == mask_reg;
    assign wr_all      = ((ack_reg | dram_valid) & mask_reg) == mask_reg;
    assign start_n     = chunk_len(size);
    assign start_mask  = lane_mask(start_n);
    assign next_offset = offset_reg + SIZE_W'(n_reg);
    assign next_n      = chunk_len(size_reg - next_offset);
    assign next_mask   = lane_mask(next_n);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            done          <= 1'b0;
            dram_en       <= '0;
            dram_rdwr     <= 1'b0;
            dram_addr     <= '0;
            dram_data_out <= '0;
            src_reg       <= '0;
            dst_reg       <= '0;
            size_reg      <= '0;
            offset_reg    <= '0;
            n_reg         <= '0;
            mask_reg      <= '0;
            ack_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        src_reg    <= src;
                        dst_reg    <= dst;
                        size_reg   <= size;
                        offset_reg <= '0;
                        if (size == '0) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= RD_REQ;
                            n_reg     <= start_n;
                            mask_reg  <= start_mask;
                            dram_en   <= start_mask;
                            dram_rdwr <= 1'b0;
                            for (int i = 0; i < LANES; i++) begin
                                dram_addr[i]     <= start_mask[i] ? src + ADDR_W'(i) : '0;
                                dram_data_out[i] <= '0;
                            end
                        end
                    end
                end
                RD_REQ: begin
                    dram_en   <= '0;
                    state_reg <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (rd_all) begin
                        state_reg <= WR_REQ;
                        dram_en   <= mask_reg;
                        dram_rdwr <= 1'b1;
                        for (int i = 0; i < LANES; i++) begin
                            dram_addr[i] <= mask_reg[i]
                                ? dst_reg + ADDR_W'(offset_reg) + ADDR_W'(i) : '0;
                            dram_data_out[i] <= mask_reg[i] ? fwd_data[i] : '0;
                        end
                    end
                end
                WR_REQ: begin
                    dram_en   <= '0;
                    ack_reg   <= '0;
                    state_reg <= WR_WAIT;
                end
                WR_WAIT: begin
                    ack_reg <= ack_reg | (dram_valid & mask_reg);
                    if (wr_all) begin
                        offset_reg    <= next_offset;
                        dram_rdwr     <= 1'b0;
                        dram_data_out <= '0;
                        if (next_offset == size_reg) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                            dram_addr <= '0;
                        end else begin
                            state_reg <= RD_REQ;
                            n_reg     <= next_n;
                            mask_reg  <= next_mask;
                            dram_en   <= next_mask;
                            for (int i = 0; i < LANES; i++) begin
                                dram_addr[i] <= next_mask[i]
                                    ? src_reg + ADDR_W'(next_offset) + ADDR_W'(i) : '0;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!en) begin
                        state_reg <= IDLE;
                        done      <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memcpy_engine.sv
// Directed bench for memcpy_engine with a lane-latency DRAM model and an address/data scoreboard.
module tb_memcpy_engine;
    localparam int LANES  = 8;
    localparam int ADDR_W = 64;
    localparam int SIZE_W = 15;

    logic                         clk = 1'b0;
    logic                         reset = 1'b1;
    logic                         en = 1'b0;
    logic [ADDR_W-1:0]            src = '0;
    logic [ADDR_W-1:0]            dst = '0;
    logic [SIZE_W-1:0]            size = '0;
    logic                         done;
    logic [LANES-1:0]             dram_en;
    logic                         dram_rdwr;
    logic [LANES-1:0][ADDR_W-1:0] dram_addr;
    logic [LANES-1:0][7:0]        dram_data_out;
    logic [LANES-1:0][7:0]        dram_data_in = '0;
    logic [LANES-1:0]             dram_valid = '0;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:4095];
    int          lat [LANES];
    bit          pend [LANES];
    bit          pwr  [LANES];
    int          cnt  [LANES];
    logic [63:0] paddr [LANES];
    logic [7:0]  pdata [LANES];
    int          writes_seen = 0;

    logic [63:0] rd_q [$];
    logic [63:0] wr_addr_q [$];
    logic [7:0]  wr_data_q [$];

    memcpy_engine dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .src           (src),
        .dst           (dst),
        .size          (size),
        .done          (done),
        .dram_en       (dram_en),
        .dram_rdwr     (dram_rdwr),
        .dram_addr     (dram_addr),
        .dram_data_out (dram_data_out),
        .dram_data_in  (dram_data_in),
        .dram_valid    (dram_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // DRAM model: requests seen on the falling edge, completion after lat[i] cycles.
    initial begin
        for (int i = 0; i < LANES; i++) begin
            pend[i] = 1'b0;
            lat[i]  = 2;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < LANES; i++) begin
                dram_valid[i]   = 1'b0;
                dram_data_in[i] = '0;
            end
            if (reset) begin
                for (int i = 0; i < LANES; i++) pend[i] = 1'b0;
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    if (pend[i]) begin
                        cnt[i]--;
                        if (cnt[i] <= 0) begin
                            pend[i]       = 1'b0;
                            dram_valid[i] = 1'b1;
                            if (pwr[i]) mem[paddr[i][11:0]] = pdata[i];
                            else        dram_data_in[i] = mem[paddr[i][11:0]];
                        end
                    end
                end
                for (int i = 0; i < LANES; i++) begin
                    if (dram_en[i]) begin
                        logic [63:0] ea;
                        logic [7:0]  ed;
                        pend[i]  = 1'b1;
                        cnt[i]   = lat[i];
                        pwr[i]   = dram_rdwr;
                        paddr[i] = dram_addr[i];
                        pdata[i] = dram_data_out[i];
                        if (dram_rdwr) begin
                            int open_rd;
                            open_rd = 0;
                            for (int j = 0; j < LANES; j++) if (pend[j] && !pwr[j]) open_rd++;
                            check("wr_before_rd_done", 64'(open_rd), 64'd0);
                            ea = wr_addr_q.size() > 0 ? wr_addr_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
                            ed = wr_data_q.size() > 0 ? wr_data_q.pop_front() : 8'hXX;
                            check("wr_addr", dram_addr[i], ea);
                            check("wr_data", 64'(dram_data_out[i]), 64'(ed));
                            writes_seen++;
                        end else begin
                            ea = rd_q.size() > 0 ? rd_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
                            check("rd_addr", dram_addr[i], ea);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_done(input string tag, input int max_cycles);
        int k;
        k = 0;
        while (done !== 1'b1 && k < max_cycles) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, 64'(done), 64'd1);
        $display("copy src=%h dst=%h size=%0d cycles=%0d", src, dst, size, k);
    endtask

    task automatic expect_copy(input logic [63:0] s, input logic [63:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            rd_q.push_back(s + 64'(i));
            wr_addr_q.push_back(d + 64'(i));
            wr_data_q.push_back(mem[12'(s + 64'(i))]);
        end
    endtask

    task automatic release_en(input string tag);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check(tag, 64'(done), 64'd0);
    endtask

    initial begin
        logic [7:0] src_bytes [0:10];
        int         k;

        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 64'(done), 64'd0);
        check("rst_en", 64'(dram_en), 64'd0);
        check("rst_rdwr", 64'(dram_rdwr), 64'd0);
        check("rst_addr0", dram_addr[0], 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single byte
        mem[12'h100] = 8'hBE;
        expect_copy(64'h100, 64'h3FF, 1);
        src = 64'h100; dst = 64'h3FF; size = 15'd1; en = 1'b1;
        wait_done("single_done", 200);
        check("single_mem", 64'(mem[12'h3FF]), 64'hBE);
        release_en("single_release");

        // Four bytes, en one cycle after the operands
        mem[12'h100] = 8'hBE; mem[12'h101] = 8'hEF; mem[12'h102] = 8'hBA; mem[12'h103] = 8'hAD;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        src = 64'h100; dst = 64'h200; size = 15'd4;
        expect_copy(64'h100, 64'h200, 4);
        @(negedge clk); en = 1'b1;
        wait_done("four_done", 200);
        check("four_mem", {32'd0, mem[12'h200], mem[12'h201], mem[12'h202], mem[12'h203]},
              64'hBEEF_BAAD);
        check("four_src", {32'd0, mem[12'h100], mem[12'h101], mem[12'h102], mem[12'h103]},
              64'hBEEF_BAAD);
        check("four_wr_q", 64'(wr_addr_q.size()), 64'd0);
        release_en("four_release");

        // Multi-chunk: 8 + 3 bytes
        for (int i = 0; i < 11; i++) begin
            src_bytes[i] = 8'($urandom_range(1, 255));
            mem[12'h100 + 12'(i)] = src_bytes[i];
        end
        expect_copy(64'h100, 64'h300, 11);
        @(negedge clk);
        src = 64'h100; dst = 64'h300; size = 15'd11; en = 1'b1;
        @(negedge clk);
        src = 64'h0; dst = 64'h0; size = 15'd2;
        wait_done("multi_done", 400);
        check("multi_writes_left", 64'(wr_addr_q.size()), 64'd0);
        check("multi_rds_left", 64'(rd_q.size()), 64'd0);
        for (int i = 0; i < 11; i++) begin
            check("multi_mem", 64'(mem[12'h300 + 12'(i)]), 64'(src_bytes[i]));
        end
        release_en("multi_release");

        // size = 0
        @(negedge clk);
        size = 15'd0; src = 64'h100; dst = 64'h500; en = 1'b1;
        @(posedge clk);
        #1;
        check("zero_done", 64'(done), 64'd1);
        check("zero_en", 64'(dram_en), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("zero_en_hold", 64'(dram_en), 64'd0);
        check("zero_done_hold", 64'(done), 64'd1);
        release_en("zero_release");

        // Staggered lane completions
        for (int i = 0; i < LANES; i++) lat[i] = LANES - i + 1;
        for (int i = 0; i < 8; i++) mem[12'h180 + 12'(i)] = 8'h40 + 8'(i * 7);
        expect_copy(64'h180, 64'h280, 8);
        @(negedge clk);
        src = 64'h180; dst = 64'h280; size = 15'd8; en = 1'b1;
        wait_done("stag_done", 400);
        for (int i = 0; i < 8; i++) begin
            check("stag_mem", 64'(mem[12'h280 + 12'(i)]), 64'(8'h40 + 8'(i * 7)));
        end
        release_en("stag_release");

        // Reset during RD_WAIT: reads are issued but no write may follow
        for (int i = 0; i < LANES; i++) lat[i] = 6;
        for (int i = 0; i < 4; i++) begin
            mem[12'h3A0 + 12'(i)] = 8'h00;
            rd_q.push_back(64'h140 + 64'(i));
            mem[12'h140 + 12'(i)] = 8'h11 + 8'(i);
        end
        writes_seen = 0;
        @(negedge clk);
        src = 64'h140; dst = 64'h3A0; size = 15'd4; en = 1'b1;
        k = 0;
        while (dram_en === '0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("abort_rd_issued", 64'(dram_en), 64'h0F);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0;
        @(posedge clk);
        #1;
        check("abort_done", 64'(done), 64'd0);
        check("abort_en", 64'(dram_en), 64'd0);
        check("abort_addr0", dram_addr[0], 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_write", 64'(writes_seen), 64'd0);
        check("abort_dst", {32'd0, mem[12'h3A0], mem[12'h3A1], mem[12'h3A2], mem[12'h3A3]}, 64'd0);
        check("abort_rds_left", 64'(rd_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
